usb_tx_pkt_sequencer: RTL and testbench

Parametrised USB full-speed transmit packet sequencer. It drives the byte-wide serializer (LSB-first shift, NRZI and bit-stuff stage) and pops payload bytes from the TX FIFO. For DATA0/DATA1 it emits SYNC, PID, payload and CRC16; for ACK/NAK/STALL it emits SYNC and PID. Adds zero-length packets, max-packet overflow detection, abort, a serializer ready/load handshake and optional CRC.

---
 rtl/usb_tx_pkt_sequencer_pkg.sv | 71 +++++++
 rtl/usb_tx_pkt_sequencer_if.sv | 28 ++
 rtl/usb_tx_pkt_sequencer_crc16.sv | 26 ++
 rtl/usb_tx_pkt_sequencer.sv | 149 ++++++++++++++
 tb/tb_usb_tx_pkt_sequencer.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/usb_tx_pkt_sequencer_pkg.sv
// Shared types, PID codes and CRC16 helpers for the USB full-speed TX packet sequencer.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    PKT_NONE  = 3'd0,
    PKT_DATA0 = 3'd1,
    PKT_DATA1 = 3'd2,
    PKT_ACK   = 3'd3,
    PKT_NAK   = 3'd4,
    PKT_STALL = 3'd5
  } pkt_code_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC   = 3'd1,
    PID    = 3'd2,
    DATA   = 3'd3,
    CRC_LO = 3'd4,
    CRC_HI = 3'd5,
    ERROR  = 3'd6,
    EOP    = 3'd7
  } state_e;

  localparam logic [3:0]  PID_NONE   = 4'b0000;
  localparam logic [3:0]  PID_DATA0  = 4'b0011;
  localparam logic [3:0]  PID_DATA1  = 4'b1011;
  localparam logic [3:0]  PID_ACK    = 4'b0010;
  localparam logic [3:0]  PID_NAK    = 4'b1010;
  localparam logic [3:0]  PID_STALL  = 4'b1110;
  localparam logic [7:0]  SYNC_BYTE  = 8'h80;
  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  // PID_NONE marks an invalid request code.
  function automatic logic [3:0] pkt_pid(input logic [2:0] code);
    case (pkt_code_e'(code))
      PKT_DATA0: return PID_DATA0;
      PKT_DATA1: return PID_DATA1;
      PKT_ACK:   return PID_ACK;
      PKT_NAK:   return PID_NAK;
      PKT_STALL: return PID_STALL;
      default:   return PID_NONE;
    endcase
  endfunction

  function automatic logic is_data_pid(input logic [3:0] pid);
    return (pid[1:0] == 2'b11);
  endfunction

  function automatic logic [7:0] pid_byte(input logic [3:0] pid);
    return {~pid, pid};
  endfunction

  function automatic logic [15:0] reflect16(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = v[15-i];
    return r;
  endfunction

  // One byte through the LSB-first (reflected) CRC16 register.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ reflect16(CRC16_POLY);
      else                c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/usb_tx_pkt_sequencer_if.sv
// Request, FIFO and serializer signals between the TX sequencer (master) and its surroundings (slave).
interface usb_tx_pkt_sequencer_if #(
  parameter int unsigned OCC_W = 7
);
  logic             tx_start;
  logic [2:0]       tx_packet;
  logic             tx_abort;
  logic [OCC_W-1:0] buffer_occupancy;
  logic [7:0]       tx_packet_data;
  logic             get_tx_packet_data;
  logic [7:0]       ser_byte;
  logic             ser_load;
  logic             ser_ready;
  logic             send_eop;
  logic             eop_done;
  logic             tx_transfer_active;
  logic             tx_error;

  modport master (
    input  tx_start, tx_packet, tx_abort, buffer_occupancy, tx_packet_data, ser_ready, eop_done,
    output get_tx_packet_data, ser_byte, ser_load, send_eop, tx_transfer_active, tx_error
  );

  modport slave (
    output tx_start, tx_packet, tx_abort, buffer_occupancy, tx_packet_data, ser_ready, eop_done,
    input  get_tx_packet_data, ser_byte, ser_load, send_eop, tx_transfer_active, tx_error
  );
endinterface

// File: rtl/usb_tx_pkt_sequencer_crc16.sv
// USB CRC16 accumulator: one payload byte folded in per enable, clear reloads the init value.
module usb_crc16
  import usb_tx_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        clear,
  input  logic        enable,
  input  logic [7:0]  data_in,
  output logic [15:0] crc_out
);
  logic [15:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clear)       crc_d = CRC16_INIT;
    else if (enable) crc_d = crc16_byte(crc_q, data_in);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) crc_q <= CRC16_INIT;
    else        crc_q <= crc_d;
  end

  assign crc_out = crc_q;
endmodule

// File: rtl/usb_tx_pkt_sequencer.sv
// USB full-speed TX packet sequencer: emits SYNC, PID, FIFO payload and CRC16 bytes to the
// serializer, then requests EOP. Byte-level outputs are decoded from the state register.
module usb_tx_pkt_sequencer
  import usb_tx_pkg::*;
#(
  parameter int unsigned MAX_PACKET_BYTES = 64,
  parameter int unsigned OCC_W            = 7,
  parameter int unsigned CRC_EN           = 1
) (
  input logic                    clk,
  input logic                    n_rst,
  usb_tx_pkt_sequencer_if.master bus
);
  localparam int unsigned CNT_W = $clog2(MAX_PACKET_BYTES + 1);

  state_e           state_q, state_d;
  logic [3:0]       pid_q, pid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [7:0]  ser_byte_c;
  logic        ser_load_c;
  logic        get_c;
  logic        send_eop_c;
  logic        xfer_c;
  logic        crc_clear_c;
  logic        crc_en_c;
  logic [15:0] crc;

  usb_crc16 u_crc (
    .clk     (clk),
    .n_rst   (n_rst),
    .clear   (crc_clear_c),
    .enable  (crc_en_c),
    .data_in (bus.tx_packet_data),
    .crc_out (crc)
  );

  // Next state, byte offer and pop; a byte moves only when ser_load meets ser_ready.
  always_comb begin
    state_d     = state_q;
    pid_d       = pid_q;
    cnt_d       = cnt_q;
    err_d       = 1'b0;
    ser_byte_c  = 8'h00;
    ser_load_c  = 1'b0;
    get_c       = 1'b0;
    send_eop_c  = 1'b0;
    crc_clear_c = 1'b0;
    crc_en_c    = 1'b0;
    xfer_c      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.tx_start) begin
          if (pkt_pid(bus.tx_packet) != PID_NONE) begin
            pid_d   = pkt_pid(bus.tx_packet);
            state_d = SYNC;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SYNC: begin
        ser_byte_c = SYNC_BYTE;
        ser_load_c = 1'b1;
        xfer_c     = bus.ser_ready;
        if (xfer_c) state_d = PID;
      end
      PID: begin
        ser_byte_c = pid_byte(pid_q);
        ser_load_c = 1'b1;
        xfer_c     = bus.ser_ready;
        if (xfer_c) begin
          if (is_data_pid(pid_q)) begin
            crc_clear_c = 1'b1;
            cnt_d       = '0;
            state_d     = DATA;
          end else begin
            state_d = EOP;
          end
        end
      end
      DATA: begin
        if (bus.buffer_occupancy == OCC_W'(0)) begin
          state_d = (CRC_EN != 0) ? CRC_LO : EOP;
        end else if (cnt_q == CNT_W'(MAX_PACKET_BYTES)) begin
          state_d = ERROR;
        end else begin
          ser_byte_c = bus.tx_packet_data;
          ser_load_c = 1'b1;
          xfer_c     = bus.ser_ready;
          if (xfer_c) begin
            get_c    = 1'b1;
            crc_en_c = 1'b1;
            cnt_d    = cnt_q + CNT_W'(1);
          end
        end
      end
      CRC_LO: begin
        ser_byte_c = ~crc[7:0];
        ser_load_c = 1'b1;
        xfer_c     = bus.ser_ready;
        if (xfer_c) state_d = CRC_HI;
      end
      CRC_HI: begin
        ser_byte_c = ~crc[15:8];
        ser_load_c = 1'b1;
        xfer_c     = bus.ser_ready;
        if (xfer_c) state_d = EOP;
      end
      ERROR: state_d = EOP;
      EOP: begin
        send_eop_c = 1'b1;
        if (bus.eop_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort wins after any same-cycle transfer has been taken above.
    if (bus.tx_abort && (state_q != IDLE) && (state_q != EOP) && (state_q != ERROR)) begin
      state_d = ERROR;
    end

    if (state_d == ERROR) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      pid_q   <= PID_NONE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pid_q   <= pid_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign bus.ser_byte           = ser_byte_c;
  assign bus.ser_load           = ser_load_c;
  assign bus.get_tx_packet_data = get_c;
  assign bus.send_eop           = send_eop_c;
  assign bus.tx_transfer_active = (state_q != IDLE);
  assign bus.tx_error           = err_q;

endmodule

// File: tb/tb_usb_tx_pkt_sequencer.sv
// Directed bench for the USB TX packet sequencer with a small FIFO model and transfer logger.
module tb_usb_tx_pkt_sequencer;
  localparam int unsigned OCC_W = 7;

  logic clk = 1'b0;
  logic n_rst;
  int   total = 0;
  int   bad   = 0;

  usb_tx_pkt_sequencer_if #(.OCC_W(OCC_W)) bus ();

  usb_tx_pkt_sequencer #(
    .MAX_PACKET_BYTES (4),
    .OCC_W            (OCC_W),
    .CRC_EN           (1)
  ) u_dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // FIFO model: first-word fall-through, popped on get.
  logic [7:0] mem [0:31];
  int rd = 0;
  int wr = 0;
  assign bus.buffer_occupancy = OCC_W'(wr - rd);
  assign bus.tx_packet_data   = (wr != rd) ? mem[rd % 32] : 8'h00;
  always @(posedge clk) if (bus.get_tx_packet_data) rd <= rd + 1;

  // Transfer logger sampled mid-cycle.
  logic [7:0] xlog [0:127];
  int nx = 0, ngets = 0, nerr = 0, gx_bad = 0;
  always @(negedge clk) begin
    if (bus.ser_load && bus.ser_ready) begin
      xlog[nx % 128] <= bus.ser_byte;
      nx <= nx + 1;
    end
    if (bus.get_tx_packet_data) ngets <= ngets + 1;
    if (bus.get_tx_packet_data && !(bus.ser_load && bus.ser_ready)) gx_bad <= gx_bad + 1;
    if (bus.tx_error) nerr <= nerr + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr % 32] = b;
    wr++;
  endtask

  task automatic start(input logic [2:0] code);
    bus.tx_packet = code;
    bus.tx_start  = 1'b1;
    tick();
    bus.tx_start  = 1'b0;
    bus.tx_packet = 3'd0;
  endtask

  // Run to EOP (bounded), confirm it is held, then complete it.
  task automatic do_eop(input string tag);
    int n = 0;
    while (bus.send_eop !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_eop_reached"}, 32'(bus.send_eop), 32'd1);
    check({tag, "_eop_noload"}, 32'(bus.ser_load), 32'd0);
    tick();
    check({tag, "_eop_held"}, 32'(bus.send_eop), 32'd1);
    bus.eop_done = 1'b1;
    tick();
    bus.eop_done = 1'b0;
    check({tag, "_idle_inactive"}, 32'(bus.tx_transfer_active), 32'd0);
    check({tag, "_idle_no_eop"}, 32'(bus.send_eop), 32'd0);
  endtask

  // Independent CRC model: MSB-first register on LSB-first bits, reflected at the end.
  function automatic logic [15:0] model_crc3(input logic [7:0] b0, input logic [7:0] b1,
                                              input logic [7:0] b2);
    logic [15:0] c;
    logic [15:0] r;
    logic [7:0]  d;
    logic        fb;
    c = 16'hFFFF;
    for (int k = 0; k < 3; k++) begin
      d = (k == 0) ? b0 : (k == 1) ? b1 : b2;
      for (int i = 0; i < 8; i++) begin
        fb = c[15] ^ d[i];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h8005;
      end
    end
    for (int i = 0; i < 16; i++) r[i] = c[15-i];
    return ~r;
  endfunction

  initial begin
    int base, g0, e0;
    logic [15:0] tcrc;

    n_rst          = 1'b0;
    bus.tx_start   = 1'b0;
    bus.tx_packet  = 3'd0;
    bus.tx_abort   = 1'b0;
    bus.ser_ready  = 1'b1;
    bus.eop_done   = 1'b0;
    #3;
    check("rst_active", 32'(bus.tx_transfer_active), 32'd0);
    check("rst_load",   32'(bus.ser_load), 32'd0);
    check("rst_byte",   32'(bus.ser_byte), 32'h00);
    check("rst_eop",    32'(bus.send_eop), 32'd0);
    check("rst_err",    32'(bus.tx_error), 32'd0);
    check("rst_get",    32'(bus.get_tx_packet_data), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    tick();

    // Invalid packet code: error pulse, stays idle.
    start(3'd6);
    check("inv_err",    32'(bus.tx_error), 32'd1);
    check("inv_active", 32'(bus.tx_transfer_active), 32'd0);
    tick();
    check("inv_err_one", 32'(bus.tx_error), 32'd0);

    // 1: ACK handshake.
    base = nx; g0 = ngets;
    start(3'd3);
    check("ack_sync_byte", 32'(bus.ser_byte), 32'h80);
    check("ack_sync_load", 32'(bus.ser_load), 32'd1);
    check("ack_active",    32'(bus.tx_transfer_active), 32'd1);
    tick();
    check("ack_pid_byte",  32'(bus.ser_byte), 32'hD2);
    do_eop("ack");
    check("ack_nbytes", 32'(nx - base), 32'd2);
    check("ack_b0",     32'(xlog[base % 128]), 32'h80);
    check("ack_b1",     32'(xlog[(base + 1) % 128]), 32'hD2);
    check("ack_gets",   32'(ngets - g0), 32'd0);

    // 2: DATA0 with three bytes and CRC.
    push(8'h01); push(8'h02); push(8'h03);
    base = nx; g0 = ngets; e0 = nerr;
    start(3'd1);
    tick(); tick();
    check("d0_first_byte", 32'(bus.ser_byte), 32'h01);
    check("d0_first_get",  32'(bus.get_tx_packet_data), 32'd1);
    do_eop("d0");
    tcrc = model_crc3(8'h01, 8'h02, 8'h03);
    check("d0_nbytes", 32'(nx - base), 32'd7);
    check("d0_pid",    32'(xlog[(base + 1) % 128]), 32'hC3);
    check("d0_pay2",   32'(xlog[(base + 4) % 128]), 32'h03);
    check("d0_crc_lo", 32'(xlog[(base + 5) % 128]), 32'(tcrc[7:0]));
    check("d0_crc_hi", 32'(xlog[(base + 6) % 128]), 32'(tcrc[15:8]));
    check("d0_gets",   32'(ngets - g0), 32'd3);
    check("d0_noerr",  32'(nerr - e0), 32'd0);

    // 3: DATA1 zero-length packet.
    base = nx; g0 = ngets; e0 = nerr;
    start(3'd2);
    do_eop("zlp");
    check("zlp_nbytes", 32'(nx - base), 32'd4);
    check("zlp_pid",    32'(xlog[(base + 1) % 128]), 32'h4B);
    check("zlp_crc_lo", 32'(xlog[(base + 2) % 128]), 32'h00);
    check("zlp_crc_hi", 32'(xlog[(base + 3) % 128]), 32'h00);
    check("zlp_gets",   32'(ngets - g0), 32'd0);
    check("zlp_noerr",  32'(nerr - e0), 32'd0);

    // 4: overflow at MAX_PACKET_BYTES=4 with six bytes queued.
    for (int i = 0; i < 6; i++) push(8'(8'hA0 + i));
    base = nx; g0 = ngets; e0 = nerr;
    start(3'd1);
    do_eop("ovf");
    check("ovf_nbytes", 32'(nx - base), 32'd6);
    check("ovf_last",   32'(xlog[(base + 5) % 128]), 32'hA3);
    check("ovf_gets",   32'(ngets - g0), 32'd4);
    check("ovf_err",    32'(nerr - e0), 32'd1);
    wr = rd;

    // 5: serializer stall, then abort.
    push(8'h11); push(8'h22); push(8'h33);
    g0 = ngets;
    start(3'd1);
    tick(); tick();
    bus.ser_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_byte", 32'(bus.ser_byte), 32'h11);
      check("stall_get",  32'(bus.get_tx_packet_data), 32'd0);
      tick();
    end
    bus.tx_abort = 1'b1;
    tick();
    bus.tx_abort = 1'b0;
    check("abort_err",    32'(bus.tx_error), 32'd1);
    check("abort_noload", 32'(bus.ser_load), 32'd0);
    tick();
    check("abort_err_one", 32'(bus.tx_error), 32'd0);
    check("abort_eop",     32'(bus.send_eop), 32'd1);
    bus.ser_ready = 1'b1;
    do_eop("abort");
    check("stall_gets", 32'(ngets - g0), 32'd0);
    wr = rd;

    // Abort coincident with a payload transfer: the byte still goes out.
    push(8'h55); push(8'h66);
    base = nx; g0 = ngets;
    start(3'd1);
    tick(); tick();
    bus.tx_abort = 1'b1;
    #1;
    check("abx_get", 32'(bus.get_tx_packet_data), 32'd1);
    tick();
    bus.tx_abort = 1'b0;
    check("abx_err",   32'(bus.tx_error), 32'd1);
    check("abx_gets",  32'(ngets - g0), 32'd1);
    check("abx_byte",  32'(xlog[(base + 2) % 128]), 32'h55);
    do_eop("abx");
    wr = rd;

    // 6: reset mid-DATA, then a clean ACK.
    push(8'h77); push(8'h88);
    start(3'd1);
    tick(); tick();
    bus.ser_ready = 1'b0;
    #1;
    n_rst = 1'b0;
    #1;
    check("mrst_active", 32'(bus.tx_transfer_active), 32'd0);
    check("mrst_load",   32'(bus.ser_load), 32'd0);
    check("mrst_byte",   32'(bus.ser_byte), 32'h00);
    check("mrst_get",    32'(bus.get_tx_packet_data), 32'd0);
    check("mrst_eop",    32'(bus.send_eop), 32'd0);
    check("mrst_err",    32'(bus.tx_error), 32'd0);
    wr = rd;
    bus.ser_ready = 1'b1;
    @(negedge clk);
    n_rst = 1'b1;
    tick();
    base = nx;
    start(3'd3);
    do_eop("post_rst");
    check("post_rst_nbytes", 32'(nx - base), 32'd2);
    check("post_rst_b0",     32'(xlog[base % 128]), 32'h80);
    check("post_rst_b1",     32'(xlog[(base + 1) % 128]), 32'hD2);

    check("get_outside_xfer", 32'(gx_bad), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
